// File: rtl/instr_mem_loader_pkg.sv
// Shared CPU-side definitions for the instruction-memory loader:
// loader state encoding, bus widths and state-class helpers.
package cpu_pkg;

   localparam int INSTR_W = 16;
   localparam int BYTE_W  = 8;

   typedef enum logic [3:0] {
      IDLE,
      CNT_HI,
      CNT_LO,
      DATA_HI,
      DATA_LO,
      WRITE,
      CHK,
      DONE,
      ERR
   } loader_state_t;

   // States in which the loader takes a byte from the stream
   function automatic logic accepts_byte(loader_state_t s);
      return s inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK};
   endfunction

   function automatic logic is_busy(loader_state_t s);
      return !(s inside {IDLE, DONE, ERR});
   endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface instr_mem_loader_if #(
   parameter int ADDR_W = 16
);
   import cpu_pkg::*;

   logic                rx_valid;
   logic [BYTE_W-1:0]   rx_data;
   logic                rx_ready;
   logic [ADDR_W-1:0]   mem_addr;
   logic [INSTR_W-1:0]  mem_wdata;
   logic                mem_wren;

   modport master (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output mem_addr,
      output mem_wdata,
      output mem_wren
   );

   modport slave (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  mem_addr,
      input  mem_wdata,
      input  mem_wren
   );

endinterface

// File: rtl/instr_mem_loader_byte_pair_assembler.sv
// Holds the high/low bytes of the instruction word being received and
// the running XOR checksum of all consumed frame bytes.
module byte_pair_assembler
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               csum_en,
   input  logic               hi_en,
   input  logic               lo_en,
   input  logic [BYTE_W-1:0]  data_in,
   output logic [INSTR_W-1:0] word,
   output logic [BYTE_W-1:0]  csum
);

   logic [1:0]        lane_en;
   logic [BYTE_W-1:0] lane_reg [2];
   logic [BYTE_W-1:0] csum_reg;

   assign lane_en = {hi_en, lo_en};

   // Lane 1 is the high byte (sent first), lane 0 the low byte
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         always_ff @(posedge clk) begin
            if (reset) begin
               lane_reg[gi] <= '0;
            end else if (lane_en[gi]) begin
               lane_reg[gi] <= data_in;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         csum_reg <= '0;
      end else if (csum_en) begin
         csum_reg <= csum_reg ^ data_in;
      end
   end

   assign word = {lane_reg[1], lane_reg[0]};
   assign csum = csum_reg;

endmodule

// File: rtl/instr_mem_loader.sv
// Receives a framed byte stream, writes the 16-bit words sequentially into
// instruction memory and holds the CPU in reset while loading or failed.
module instr_mem_loader
   import cpu_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   instr_mem_loader_if.master bus,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] loaded_words
);

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   loader_state_t       state_reg, state_next;
   logic [INSTR_W-1:0]  count_reg;
   logic [ADDR_W-1:0]   word_idx_reg;
   logic                rx_ready_reg;
   logic                mem_wren_reg;
   logic                cpu_hold_reg;
   logic                busy_reg;
   logic                done_reg;
   logic                error_reg;

   logic                fire;
   logic                load_begin;
   logic                last_word;
   logic [INSTR_W-1:0]  count_full;
   logic [INSTR_W-1:0]  word;
   logic [BYTE_W-1:0]   csum;

   assign fire       = bus.rx_valid && rx_ready_reg;
   assign load_begin = start && (state_reg == IDLE || state_reg == ERR);
   assign count_full = {count_reg[15:8], bus.rx_data};
   assign last_word  = (32'(word_idx_reg) + 32'd1) == 32'(count_reg);

   byte_pair_assembler u_asm (
      .clk     (clk),
      .reset   (reset),
      .clear   (load_begin),
      .csum_en (fire && state_reg inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO}),
      .hi_en   (fire && state_reg == DATA_HI),
      .lo_en   (fire && state_reg == DATA_LO),
      .data_in (bus.rx_data),
      .word    (word),
      .csum    (csum)
   );

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (start) state_next = CNT_HI;
         CNT_HI:  if (fire) state_next = CNT_LO;
         CNT_LO: begin
            if (fire) begin
               if ({1'b0, count_full} > DEPTH_L) begin
                  state_next = ERR;
               end else if (count_full == '0) begin
                  state_next = CHK;
               end else begin
                  state_next = DATA_HI;
               end
            end
         end
         DATA_HI: if (fire) state_next = DATA_LO;
         DATA_LO: if (fire) state_next = WRITE;
         WRITE:   state_next = last_word ? CHK : DATA_HI;
         CHK: begin
            if (fire) state_next = (bus.rx_data == csum) ? DONE : ERR;
         end
         DONE:    state_next = IDLE;
         ERR:     if (start) state_next = CNT_HI;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with it
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         word_idx_reg <= '0;
         rx_ready_reg <= 1'b0;
         mem_wren_reg <= 1'b0;
         cpu_hold_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rx_ready_reg <= accepts_byte(state_next);
         busy_reg     <= is_busy(state_next);
         mem_wren_reg <= (state_next == WRITE);
         done_reg     <= (state_next == DONE);
         cpu_hold_reg <= (state_next != IDLE);

         if (load_begin) begin
            error_reg    <= 1'b0;
            word_idx_reg <= '0;
            count_reg    <= '0;
         end else begin
            if (state_next == ERR) error_reg <= 1'b1;
            if (fire && state_reg == CNT_HI) count_reg[15:8] <= bus.rx_data;
            if (fire && state_reg == CNT_LO) count_reg[7:0] <= bus.rx_data;
            if (state_reg == WRITE) word_idx_reg <= word_idx_reg + ADDR_W'(1);
         end
      end
   end

   assign bus.rx_ready  = rx_ready_reg;
   assign bus.mem_wren  = mem_wren_reg;
   assign bus.mem_addr  = word_idx_reg;
   assign bus.mem_wdata = word;

   assign cpu_hold     = cpu_hold_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign error        = error_reg;
   assign loaded_words = word_idx_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: fixed frame table, hand-written
// reset/start corner cases and randomized frames against a frame-level model.
module tb_instr_mem_loader;
   import cpu_pkg::*;

   localparam int DEPTH  = 256;
   localparam int ADDR_W = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              cpu_hold, busy, done, error;
   logic [ADDR_W-1:0] loaded_words;

   instr_mem_loader_if #(.ADDR_W(ADDR_W)) ifc ();

   instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .bus          (ifc),
      .cpu_hold     (cpu_hold),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .loaded_words (loaded_words)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } wr_t;

   typedef struct packed {
      logic [15:0]       count;
      logic [3:0][15:0]  words;
      logic [7:0]        csum;
      logic [15:0]       exp_loaded;
      logic              exp_done;
      logic              exp_error;
   } vec_t;

   int          compared   = 0;
   int          mismatched = 0;
   int          done_cnt   = 0;
   int          gap_max    = 0;
   logic        done_prev  = 1'b0;
   wr_t         got_q[$];
   logic [15:0] frame_words [DEPTH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write/done monitor
   always @(negedge clk) begin
      if (reset) begin
         done_prev = 1'b0;
      end else begin
         if (ifc.mem_wren) begin
            got_q.push_back('{addr: ifc.mem_addr, data: ifc.mem_wdata});
            check("rx_ready_in_write", ifc.rx_ready, 1'b0);
         end
         if (done_prev) check("hold_after_done", cpu_hold, 1'b0);
         if (done) begin
            done_cnt++;
            check("hold_during_done", cpu_hold, 1'b1);
         end
         done_prev = done;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic int gap();
      return int'($urandom_range(0, gap_max));
   endfunction

   // Called at a negedge; returns at the negedge after the byte is consumed
   task automatic send_byte(input logic [7:0] b, input int gap_after);
      int n = 0;
      ifc.rx_valid = 1'b1;
      ifc.rx_data  = b;
      while (ifc.rx_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("rx_ready_timeout", ifc.rx_ready, 1'b1);
      @(negedge clk);
      ifc.rx_valid = 1'b0;
      ifc.rx_data  = 8'($urandom);
      repeat (gap_after) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic play_frame(input string tag, input logic [15:0] count, input logic [7:0] csum_sent,
                             input logic exp_done, input logic exp_error, input int exp_loaded);
      int d0;
      got_q.delete();
      d0 = done_cnt;
      pulse_start();
      check({tag, "_start_ready"}, ifc.rx_ready, 1'b1);
      check({tag, "_start_error"}, error, 1'b0);
      check({tag, "_start_hold"}, {cpu_hold, busy}, 2'b11);
      check({tag, "_start_loaded"}, loaded_words, 0);
      send_byte(count[15:8], gap());
      if (int'(count) > DEPTH) begin
         send_byte(count[7:0], 0);
         check({tag, "_oversize_ready"}, ifc.rx_ready, 1'b0);
      end else begin
         send_byte(count[7:0], gap());
         for (int i = 0; i < int'(count); i++) begin
            send_byte(frame_words[i][15:8], gap());
            send_byte(frame_words[i][7:0], gap());
         end
         send_byte(csum_sent, 0);
      end
      check({tag, "_done"}, done, exp_done);
      check({tag, "_error"}, error, exp_error);
      check({tag, "_hold_busy"}, {cpu_hold, busy}, 2'b10);
      check({tag, "_loaded"}, loaded_words, exp_loaded);
      check({tag, "_nwrites"}, got_q.size(), exp_loaded);
      for (int i = 0; i < got_q.size() && i < exp_loaded; i++) begin
         check({tag, "_waddr"}, got_q[i].addr, i);
         check({tag, "_wdata"}, got_q[i].data, frame_words[i]);
      end
      @(negedge clk);
      check({tag, "_done_count"}, done_cnt - d0, exp_done ? 1 : 0);
      check({tag, "_after_hold"}, cpu_hold, exp_error);
      check({tag, "_after_error"}, error, exp_error);
      $display("frame %s count=%0h csum=%0h done=%0b error=%0b loaded=%0d", tag, count, csum_sent,
               exp_done, exp_error, exp_loaded);
   endtask

   function automatic vec_t mk_vec(input logic [15:0] count, input logic [15:0] w0, input logic [15:0] w1,
                                   input logic [15:0] w2, input logic [7:0] csum, input logic [15:0] loaded,
                                   input logic d, input logic e);
      vec_t v;
      v.count      = count;
      v.words      = {16'h0000, w2, w1, w0};
      v.csum       = csum;
      v.exp_loaded = loaded;
      v.exp_done   = d;
      v.exp_error  = e;
      return v;
   endfunction

   vec_t vecs [7];

   initial begin
      logic [15:0] cnt;
      logic [7:0]  exp_csum, sent;
      logic        corrupt, fits;

      vecs[0] = mk_vec(16'h0002, 16'h1234, 16'hABCD, 16'h0000, 8'h42, 16'd2, 1'b1, 1'b0);
      vecs[1] = mk_vec(16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'd0, 1'b1, 1'b0);
      vecs[2] = mk_vec(16'h0001, 16'hFF00, 16'h0000, 16'h0000, 8'h00, 16'd1, 1'b0, 1'b1);
      vecs[3] = mk_vec(16'h0101, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'd0, 1'b0, 1'b1);
      vecs[4] = mk_vec(16'h0003, 16'h0001, 16'h0002, 16'h0003, 8'h03, 16'd3, 1'b1, 1'b0);
      vecs[5] = mk_vec(16'h8000, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'd0, 1'b0, 1'b1);
      vecs[6] = mk_vec(16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h01, 16'd0, 1'b0, 1'b1);

      reset        = 1'b1;
      start        = 1'b0;
      ifc.rx_valid = 1'b0;
      ifc.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_outputs", {ifc.rx_ready, ifc.mem_wren, cpu_hold, busy, done, error}, 6'b0);
      check("reset_addr", ifc.mem_addr, 0);
      check("reset_wdata", ifc.mem_wdata, 0);
      check("reset_loaded", loaded_words, 0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_hold", {cpu_hold, busy}, 2'b00);

      // Table vectors, first back-to-back then with random source gaps
      for (int p = 0; p < 2; p++) begin
         gap_max = p * 3;
         for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 4; k++) frame_words[k] = vecs[i].words[k];
            play_frame($sformatf("vec%0d_p%0d", i, p), vecs[i].count, vecs[i].csum,
                       vecs[i].exp_done, vecs[i].exp_error, int'(vecs[i].exp_loaded));
         end
      end

      // Start while busy is ignored; reset mid-load returns to IDLE
      gap_max = 0;
      frame_words[0] = 16'h1234;
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      @(negedge clk);
      check("midload_loaded", loaded_words, 1);
      pulse_start();
      check("busy_start_loaded", loaded_words, 1);
      check("busy_start_busy", busy, 1'b1);
      send_byte(8'hAB, 0);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_outputs", {ifc.rx_ready, cpu_hold, busy, error, done}, 5'b0);
      check("midreset_loaded", loaded_words, 0);
      reset = 1'b0;
      @(negedge clk);
      $display("midload reset sequence done");

      // Randomized frames against a frame-level model
      for (int t = 0; t < 40; t++) begin
         gap_max = int'($urandom_range(0, 3));
         if (t == 20)                      cnt = 16'(DEPTH);
         else if ($urandom_range(0, 9) == 0) cnt = 16'(DEPTH + 1 + int'($urandom_range(0, 65535 - DEPTH - 1)));
         else                              cnt = 16'($urandom_range(0, 8));
         fits     = int'(cnt) <= DEPTH;
         exp_csum = cnt[15:8] ^ cnt[7:0];
         if (fits) begin
            for (int i = 0; i < int'(cnt); i++) begin
               frame_words[i] = 16'($urandom);
               exp_csum       = exp_csum ^ frame_words[i][15:8] ^ frame_words[i][7:0];
            end
         end
         corrupt = ($urandom_range(0, 4) == 0);
         sent    = corrupt ? (exp_csum ^ 8'($urandom_range(1, 255))) : exp_csum;
         play_frame($sformatf("rnd%0d", t), cnt, sent, fits && !corrupt, !(fits && !corrupt),
                    fits ? int'(cnt) : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
